serial_adder_ctrl: RTL

//  Sequencer that reuses one 1-bit full-adder datapath (full_adder, ports a_in/b_in/carry_in ->
//  sum_out/carry_out) to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.

---
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands LSB first through one shared 1-bit full adder
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   start_in              request, accepted only while idle
//   a_in, b_in, carry_in  operands and carry into bit 0, captured on an accepted start
//   busy_out              high while an addition is in progress or completing
//   done_out              one-cycle pulse when the result outputs are updated
//   sum_out, carry_out    registered result, held until the next done
//   overflow_out          signed overflow (carry into MSB xor carry out of MSB)
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic carry_in,
    output logic sum_out,
    output logic carry_out
);
    assign sum_out = a_in ^ b_in ^ carry_in;
    assign carry_out = (a_in & b_in) | (carry_in & (a_in ^ b_in));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
    logic [WIDTH:0] s_cat;
    logic [CW-1:0] cnt;
    logic c_reg, fa_sum, fa_carry, last;

    full_adder u_fa (
        .a_in(a_sh[0]),
        .b_in(b_sh[0]),
        .carry_in(c_reg),
        .sum_out(fa_sum),
        .carry_out(fa_carry)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    assign s_cat = {fa_sum, s_sh};
    assign s_nxt = s_cat[WIDTH:1];
    assign last = cnt == CW'(WIDTH - 1);
    assign busy_out = state != IDLE;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE  ? (start_in ? SHIFT : IDLE) :
                    state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            done_out <= 1'b0;
            sum_out <= '0;
            carry_out <= 1'b0;
            overflow_out <= 1'b0;
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c_reg <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            done_out <= state == SHIFT && last;
            if (state == IDLE && start_in) begin
                a_sh <= a_in;
                b_sh <= b_in;
                c_reg <= carry_in;
                cnt <= '0;
            end
            if (state == SHIFT) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                s_sh <= s_nxt;
                c_reg <= fa_carry;
                if (!last)
                    cnt <= cnt + 1'b1;
                // On the final bit c_reg holds the carry into the MSB (captured carry_in when WIDTH=1).
                if (last) begin
                    sum_out <= s_nxt;
                    carry_out <= fa_carry;
                    overflow_out <= c_reg ^ fa_carry;
                end
            end
        end
    end
endmodule
